registered_decrementer32: RTL and testbench

REGISTERED_DECREMENTER32 -- requirements
Module: registered_decrementer32

---
 rtl/registered_decrementer32_if.sv | 24 ++
 rtl/registered_decrementer32.sv | 100 ++++++++++
 tb/tb_registered_decrementer32.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/registered_decrementer32_if.sv
// Operand/result handshake bundle for registered_decrementer32.
// master = upstream/downstream environment, slave = the decrementer.
interface registered_decrementer32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_inc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_borrow;

  modport master (
    output in_valid, in_sum, in_inc, out_ready,
    input  in_ready, out_valid, out_data, out_borrow
  );

  modport slave (
    input  in_valid, in_sum, in_inc, out_ready,
    output in_ready, out_valid, out_data, out_borrow
  );
endinterface

// File: rtl/registered_decrementer32.sv
// Recovers the original operand (sum - inc) through an operand register (S1)
// feeding a 2-entry result FIFO; optional clamp-to-zero on borrow.
module registered_decrementer32 #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  registered_decrementer32_if.slave bus,
  output logic [15:0]               count
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic [WIDTH-1:0] s1_inc_q, s1_inc_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [15:0]      count_q, count_d;

  logic             out_valid;
  logic             push;
  logic             pop;
  logic             drain;
  logic [WIDTH-1:0] diff;
  logic             wr_borrow;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] head_data;
  logic             head_borrow;

  // Room exists whenever S1 plus FIFO hold fewer than three results in flight.
  assign bus.in_ready = !RESET && (({2'b00, s1_valid_q} + {1'b0, occ_q}) < 3'd3);
  assign out_valid    = (occ_q != 2'd0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = out_valid && bus.out_ready;
  assign drain        = s1_valid_q && ((occ_q != 2'd2) || pop);

  assign diff      = s1_sum_q - s1_inc_q;
  assign wr_borrow = (s1_inc_q > s1_sum_q);
  assign wr_data   = (SATURATE && wr_borrow) ? '0 : diff;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [WIDTH-1:0] data_q;
      logic             borrow_q;
      always_ff @(posedge CLK) begin
        if (drain && (wr_ptr_q == 1'(gi))) begin
          data_q   <= wr_data;
          borrow_q <= wr_borrow;
        end
      end
    end
  endgenerate

  assign head_data   = rd_ptr_q ? g_entry[1].data_q   : g_entry[0].data_q;
  assign head_borrow = rd_ptr_q ? g_entry[1].borrow_q : g_entry[0].borrow_q;

  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? head_data : '0;
  assign bus.out_borrow = out_valid && head_borrow;
  assign count          = count_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_inc_d   = s1_inc_q;
    if (push) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = bus.in_sum;
      s1_inc_d   = bus.in_inc;
    end else if (drain) begin
      s1_valid_d = 1'b0;
    end
    // occupancy stays in 0..2: a drain at 2 is only allowed alongside a pop
    occ_d    = occ_q + {1'b0, drain} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ drain;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {15'd0, pop};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_inc_q   <= '0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_inc_q   <= s1_inc_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_registered_decrementer32.sv
// Directed bench: vector table on wrap and saturating instances, plus
// backpressure, mid-flight reset, streaming and counter-wrap sequences.
module tb_registered_decrementer32;
  logic        CLK;
  logic        RESET;
  logic [15:0] count0;
  logic [15:0] count1;

  int tests = 0;
  int fails = 0;

  registered_decrementer32_if #(.WIDTH(32)) b0 ();
  registered_decrementer32_if #(.WIDTH(32)) b1 ();

  registered_decrementer32 #(.WIDTH(32), .SATURATE(1'b0)) dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b0),
    .count (count0)
  );

  registered_decrementer32 #(.WIDTH(32), .SATURATE(1'b1)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b1),
    .count (count1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] sum;
    logic [31:0] inc;
    logic [31:0] exp_wrap;
    logic [31:0] exp_sat;
    logic        exp_borrow;
  } vec_t;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stream(input int n, input bit check_data, output int stalls, output int gaps);
    logic [31:0] exp_q[$];
    int acc;
    int pops;
    int cyc;
    bit hs;
    acc = 0; pops = 0; cyc = 0; stalls = 0; gaps = 0;
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b1;
    b0.in_sum    = $urandom;
    b0.in_inc    = $urandom;
    while (pops < n && cyc < n + 50) begin
      if (acc < n && !b0.in_ready) stalls++;
      if (b0.out_valid) begin
        if (check_data) begin
          if (exp_q.size() == 0) chk("stream_extra", 64'd1, 64'd0);
          else chk("stream_data", {32'd0, b0.out_data}, {32'd0, exp_q.pop_front()});
        end
        pops++;
      end else if (pops > 0) begin
        gaps++;
      end
      hs = b0.in_valid && b0.in_ready;
      if (hs) begin
        if (check_data) exp_q.push_back(b0.in_sum - b0.in_inc);
        acc++;
      end
      step();
      cyc++;
      if (hs) begin
        if (acc < n) begin
          b0.in_sum = $urandom;
          b0.in_inc = $urandom;
        end else begin
          b0.in_valid = 1'b0;
        end
      end
    end
    b0.in_valid = 1'b0;
    chk("stream_pops", 64'(pops), 64'(n));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   acc;
    int   pops;
    int   stale;
    int   stalls;
    int   gaps;
    bit   hs;

    vecs[0] = '{32'h0000000A, 32'h00000003, 32'h00000007, 32'h00000007, 1'b0};
    vecs[1] = '{32'h00000002, 32'h00000005, 32'hFFFFFFFD, 32'h00000000, 1'b1};
    vecs[2] = '{32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};

    RESET = 1'b1;
    b0.in_valid = 1'b0; b0.in_sum = '0; b0.in_inc = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_sum = '0; b1.in_inc = '0; b1.out_ready = 1'b0;

    // ---- reset state
    step();
    step();
    chk("rst_in_ready", {63'd0, b0.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, b0.out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, b0.out_data}, 64'd0);
    chk("rst_out_borrow", {63'd0, b0.out_borrow}, 64'd0);
    chk("rst_count", {48'd0, count0}, 64'd0);
    RESET = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, b0.in_ready}, 64'd1);

    // ---- vector table: one pair at a time on both instances
    for (int i = 0; i < 6; i++) begin
      b0.in_valid = 1'b1; b0.in_sum = vecs[i].sum; b0.in_inc = vecs[i].inc; b0.out_ready = 1'b1;
      b1.in_valid = 1'b1; b1.in_sum = vecs[i].sum; b1.in_inc = vecs[i].inc; b1.out_ready = 1'b1;
      chk("vec_in_ready", {63'd0, b0.in_ready}, 64'd1);
      step();
      b0.in_valid = 1'b0;
      b1.in_valid = 1'b0;
      chk("vec_latency_not_yet", {63'd0, b0.out_valid}, 64'd0);
      step();
      chk("vec_out_valid", {63'd0, b0.out_valid}, 64'd1);
      chk("vec_wrap_data", {32'd0, b0.out_data}, {32'd0, vecs[i].exp_wrap});
      chk("vec_wrap_borrow", {63'd0, b0.out_borrow}, {63'd0, vecs[i].exp_borrow});
      chk("vec_sat_data", {32'd0, b1.out_data}, {32'd0, vecs[i].exp_sat});
      chk("vec_sat_borrow", {63'd0, b1.out_borrow}, {63'd0, vecs[i].exp_borrow});
      $display("[TB] vec %0d: %08h - %08h -> wrap %08h sat %08h borrow %0b",
               i, vecs[i].sum, vecs[i].inc, b0.out_data, b1.out_data, b0.out_borrow);
      step();
      chk("vec_popped", {63'd0, b0.out_valid}, 64'd0);
    end
    chk("vec_count", {48'd0, count0}, 64'd6);
    chk("vec_count_sat", {48'd0, count1}, 64'd6);
    chk("idle_out_data_zero", {32'd0, b0.out_data}, 64'd0);

    // ---- backpressure: 5 offers with out_ready low, exactly 3 accepted
    b0.out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      b0.in_valid = 1'b1;
      b0.in_sum   = 32'(100 + acc);
      b0.in_inc   = 32'd1;
      hs = b0.in_ready;
      step();
      if (hs) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in_ready_low", {63'd0, b0.in_ready}, 64'd0);
    chk("bp_head_valid", {63'd0, b0.out_valid}, 64'd1);
    chk("bp_head_held", {32'd0, b0.out_data}, 64'd99);
    step();
    chk("bp_head_stable", {32'd0, b0.out_data}, 64'd99);

    b0.out_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 30 && pops < 5; c++) begin
      hs = b0.in_valid && b0.in_ready;
      if (b0.out_valid) begin
        chk("bp_order", {32'd0, b0.out_data}, 64'(99 + pops));
        $display("[TB] bp pop %0d: data %0d", pops, b0.out_data);
        pops++;
      end
      step();
      if (hs) begin
        acc++;
        if (acc < 5) b0.in_sum = 32'(100 + acc);
        else b0.in_valid = 1'b0;
      end
    end
    b0.in_valid = 1'b0;
    chk("bp_total_accepted", 64'(acc), 64'd5);
    chk("bp_total_pops", 64'(pops), 64'd5);
    chk("bp_count", {48'd0, count0}, 64'd11);

    // ---- reset with S1 full and FIFO at 2, handshakes offered on the reset edge
    b0.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      b0.in_valid = 1'b1;
      b0.in_sum   = 32'(50 + acc);
      b0.in_inc   = 32'd0;
      hs = b0.in_ready;
      step();
      if (hs) acc++;
    end
    chk("mf_filled", 64'(acc), 64'd3);
    chk("mf_full", {63'd0, b0.in_ready}, 64'd0);
    RESET = 1'b1;
    b0.in_valid = 1'b1;
    b0.out_ready = 1'b1;
    #1;
    chk("mf_in_ready_in_reset", {63'd0, b0.in_ready}, 64'd0);
    step();
    RESET = 1'b0;
    b0.in_valid = 1'b0;
    #1;
    chk("mf_out_valid", {63'd0, b0.out_valid}, 64'd0);
    chk("mf_out_data", {32'd0, b0.out_data}, 64'd0);
    chk("mf_count", {48'd0, count0}, 64'd0);
    chk("mf_in_ready", {63'd0, b0.in_ready}, 64'd1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (b0.out_valid) stale++;
    end
    chk("mf_no_stale", 64'(stale), 64'd0);
    chk("mf_count_still_zero", {48'd0, count0}, 64'd0);

    // ---- streaming 1000 random pairs
    stream(1000, 1'b1, stalls, gaps);
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_gaps", 64'(gaps), 64'd0);
    chk("stream_count", {48'd0, count0}, 64'd1000);
    $display("[TB] stream: 1000 pairs, count %0d", count0);

    // ---- counter wrap: 65537 pops total since reset
    stream(64537, 1'b0, stalls, gaps);
    chk("wrap_count", {48'd0, count0}, 64'd1);
    $display("[TB] wrap: count %0d", count0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
